// File: rtl/dsp_pkg.sv
// ----------------------------------------------------------------------------
// dsp_pkg
// Shared types and helpers for the DSP output path.
//   decim_state_e    : decimator state (IDLE = disabled, ACCUM = accumulating)
//   DECIM_FIFO_DEPTH : entries in the output ready/valid buffer
//   acc_width()      : accumulator width that cannot overflow over 2^max samples
// ----------------------------------------------------------------------------
package dsp_pkg;

    typedef enum logic {
        IDLE,
        ACCUM
    } decim_state_e;

    localparam int unsigned DECIM_FIFO_DEPTH = 2;

    // Summing 2^max_decim_log2 samples of data_width bits needs max_decim_log2
    // extra bits of headroom.
    function automatic int unsigned acc_width(input int unsigned data_width,
                                              input int unsigned max_decim_log2);
        return data_width + max_decim_log2;
    endfunction

endpackage

// File: rtl/dsp_out_skid_fifo.sv
// ----------------------------------------------------------------------------
// dsp_out_skid_fifo
// Small in-order ready/valid buffer for decimated results.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or full with a pop)
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   full/empty : occupancy flags, registered
//   head_data  : oldest entry; reads 0 after reset
// Pointer wrap relies on DECIM_FIFO_DEPTH being a power of two.
// ----------------------------------------------------------------------------
module dsp_out_skid_fifo
    import dsp_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned PTR_W = (DECIM_FIFO_DEPTH > 1) ? $clog2(DECIM_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DECIM_FIFO_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DECIM_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full      = (count_q == CNT_W'(DECIM_FIFO_DEPTH));
        empty     = (count_q == '0);
        do_pop    = pop && !empty;
        // When full, a simultaneous pop frees the slot the write lands in.
        do_push   = push && (!full || do_pop);
        head_data = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DECIM_FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dsp_out_decim.sv
// ----------------------------------------------------------------------------
// dsp_out_decim
// Boxcar-averaging decimator on the FIR output stream. Averages 2^decim_log2
// samples and pushes one result per window into a 2-entry ready/valid buffer.
// The input stream cannot stall, so a result arriving at a full buffer is
// dropped and recorded in the sticky overflow flag.
//
// Ports:
//   clk, rst_n : DSP clock, asynchronous active-low reset
//   enable     : 0 keeps accumulator/count cleared and ignores input
//   decim_log2 : log2 decimation ratio, clamped to MAX_DECIM_LOG2
//   in_data    : signed sample; in_valid strobes one sample per cycle
//   out_data   : head result of the buffer; out_valid when non-empty
//   out_ready  : consumer pop (out_valid && out_ready)
//   clear_ovf  : synchronous clear of overflow (a same-cycle drop wins)
//   overflow   : sticky, a result was dropped
//
// Build option: define DSP_DECIM_ROUND_EN for round-half-up averaging;
// otherwise the average truncates toward minus infinity.
// ----------------------------------------------------------------------------
module dsp_out_decim
    import dsp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned MAX_DECIM_LOG2 = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enable,
    input  logic [$clog2(MAX_DECIM_LOG2+1)-1:0]   decim_log2,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    input  logic                                  in_valid,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    input  logic                                  clear_ovf,
    output logic                                  overflow
);

    localparam int unsigned RATIO_W = $clog2(MAX_DECIM_LOG2 + 1);
    localparam int unsigned ACC_W   = acc_width(DATA_WIDTH, MAX_DECIM_LOG2);
    localparam int unsigned CNT_W   = MAX_DECIM_LOG2;
    localparam logic [RATIO_W-1:0] MAX_RATIO = RATIO_W'(MAX_DECIM_LOG2);

    decim_state_e            state_q;
    logic [RATIO_W-1:0]      ratio_q;
    logic [RATIO_W-1:0]      ratio;
    logic                    restart;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_plus;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] round_term;
    logic signed [ACC_W-1:0] sum;

    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [CNT_W-1:0]        cnt_base;
    logic [CNT_W-1:0]        cnt_last;

    logic                    window_end;
    logic [DATA_WIDTH-1:0]   result;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic                    drop;
    logic                    overflow_q;

    always_comb begin
        ratio   = (decim_log2 > MAX_RATIO) ? MAX_RATIO : decim_log2;
        // A ratio change restarts the window; a sample in this same cycle is
        // its first sample, so the clear applies to the base, not the result.
        restart  = (state_q == IDLE) || (ratio != ratio_q);
        acc_base = restart ? '0 : acc_q;
        cnt_base = restart ? '0 : cnt_q;

        sample_ext = {{MAX_DECIM_LOG2{in_data[DATA_WIDTH-1]}}, in_data};
        acc_plus   = acc_base + sample_ext;
        cnt_last   = ~({CNT_W{1'b1}} << ratio);
        window_end = enable && in_valid && (cnt_base == cnt_last);

`ifdef DSP_DECIM_ROUND_EN
        round_term = (ratio == '0) ? '0 : (ACC_W'(1) << (ratio - RATIO_W'(1)));
`else
        round_term = '0;
`endif
        sum    = acc_plus + round_term;
        // The mean of DATA_WIDTH-bit samples always fits back in DATA_WIDTH.
        result = DATA_WIDTH'(sum >>> ratio);

        if (!enable || window_end) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            acc_d = acc_plus;
            cnt_d = cnt_base + CNT_W'(1);
        end else begin
            acc_d = acc_base;
            cnt_d = cnt_base;
        end

        fifo_pop = out_ready && !fifo_empty;
        drop     = window_end && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ratio_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE:    state_q <= enable ? ACCUM : IDLE;
                ACCUM:   state_q <= enable ? ACCUM : IDLE;
                default: state_q <= IDLE;
            endcase
            ratio_q <= ratio;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    dsp_out_skid_fifo #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (window_end),
        .push_data (result),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (out_data)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dsp_out_decim.sv
// ----------------------------------------------------------------------------
// tb_dsp_out_decim
// Scoreboard bench: the stimulus process predicts each averaged result with a
// window-of-samples model and queues it; a monitor pops on every handshake.
// ----------------------------------------------------------------------------
module tb_dsp_out_decim;

    localparam int DW    = 16;
    localparam int MAXL  = 4;
    localparam int RW    = $clog2(MAXL + 1);
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [RW-1:0] decim_log2 = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          clear_ovf = 1'b0;
    logic          overflow;

    always #5 clk = ~clk;

    dsp_out_decim #(
        .DATA_WIDTH     (DW),
        .MAX_DECIM_LOG2 (MAXL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .decim_log2 (decim_log2),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clear_ovf  (clear_ovf),
        .overflow   (overflow)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int win[$];          // samples of the window in progress
    int prev_r = 0;      // ratio seen at the previous edge
    int exp_q[$];        // results expected to leave the buffer, in order
    int occ = 0;         // buffer occupancy after the next edge
    bit ovf = 1'b0;      // overflow after the next edge
    int occ_shown = 0;   // occupancy the DUT currently shows
    bit ovf_shown = 1'b0;
    bit mon_en = 1'b0;
    int mon_exp;

    // Controls applied on the next step
    bit cfg_en = 1'b0;
    int cfg_ratio = 0;
    bit cfg_ready = 1'b0;
    bit cfg_clr = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Effect of the coming rising edge, from the current port values.
    task automatic model_step();
        int  r;
        bit  push;
        bit  pop;
        bit  drop;
        int  res;
        longint s;
        r    = (int'(decim_log2) > MAXL) ? MAXL : int'(decim_log2);
        push = 1'b0;
        res  = 0;
        if (!enable) begin
            win.delete();
        end else begin
            if (r != prev_r) win.delete();
            if (in_valid) begin
                win.push_back(int'($signed(in_data)));
                if (win.size() == (1 << r)) begin
                    s = 0;
                    foreach (win[i]) s += win[i];
`ifdef DSP_DECIM_ROUND_EN
                    if (r > 0) s += longint'(1) << (r - 1);
`endif
                    res  = int'(s >>> r);
                    push = 1'b1;
                    win.delete();
                end
            end
        end
        prev_r = r;
        pop  = out_ready && (occ > 0);
        drop = push && (occ == DEPTH) && !pop;
        if (push && !drop) begin
            exp_q.push_back(res);
            occ++;
        end
        if (pop) occ--;
        if (drop) ovf = 1'b1;
        else if (clear_ovf) ovf = 1'b0;
    endtask

    task automatic step(input bit v, input int d);
        @(posedge clk);
        #1;
        occ_shown  = occ;
        ovf_shown  = ovf;
        enable     = cfg_en;
        decim_log2 = RW'(cfg_ratio);
        out_ready  = cfg_ready;
        clear_ovf  = cfg_clr;
        in_valid   = v;
        in_data    = DW'(d);
        model_step();
    endtask

    task automatic chk_out(input string name, input int val);
        check({name, "_valid"}, longint'(out_valid), 1);
        check(name, longint'($signed(out_data)), longint'(val));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        in_valid  = 1'b0;
        clear_ovf = 1'b0;
        cfg_en    = 1'b0;
        cfg_clr   = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_overflow", longint'(overflow), 0);
        win.delete();
        exp_q.delete();
        occ = 0; ovf = 1'b0; prev_r = 0; occ_shown = 0; ovf_shown = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        model_step();
    endtask

    // Monitor: samples mid-cycle; a handshake seen here completes on the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("out_valid", longint'(out_valid), longint'(occ_shown > 0));
                check("overflow", longint'(overflow), longint'(ovf_shown));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pop: got data %0d, expected no entry (t=%0t)",
                                 $signed(out_data), $time);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("out_data", longint'($signed(out_data)), longint'(mon_exp));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        do_reset();

        // Plain average
        cfg_en = 1'b1; cfg_ratio = 2; cfg_ready = 1'b1;
        step(1, 1000); step(1, 2000); step(1, 3000); step(1, 4000);
        step(0, 0);
        chk_out("avg", 2500);
        step(0, 0);
        check("avg_single", longint'(out_valid), 0);

        // Signed rounding, sum -9 over 4
        step(1, -3); step(1, -2); step(1, -2); step(1, -2);
        step(0, 0);
`ifdef DSP_DECIM_ROUND_EN
        chk_out("round", -2);
`else
        chk_out("round", -3);
`endif

        // Full scale, no wrap
        cfg_ratio = 4;
        repeat (16) step(1, 32767);
        step(0, 0);
        chk_out("fs_pos", 32767);
        repeat (16) step(1, -32768);
        step(0, 0);
        chk_out("fs_neg", -32768);

        // Back-pressure: third window is dropped
        cfg_ratio = 1; cfg_ready = 1'b0;
        repeat (6) step(1, 10);
        step(0, 0);
        chk_out("bp_head", 10);
        check("bp_ovf", longint'(overflow), 1);
        cfg_ready = 1'b1;
        step(0, 0); step(0, 0); step(0, 0);
        check("bp_drained", longint'(out_valid), 0);
        cfg_clr = 1'b1;
        step(0, 0);
        cfg_clr = 1'b0;
        step(0, 0);
        check("bp_ovf_clr", longint'(overflow), 0);

        // Pass-through
        cfg_ratio = 0;
        step(1, 5);
        step(1, -7);
        chk_out("pt0", 5);
        step(1, 9);
        chk_out("pt1", -7);
        step(0, 0);
        chk_out("pt2", 9);
        step(0, 0);

        // Ratio change mid-window discards the partial window
        cfg_ratio = 2;
        step(1, 100); step(1, 200); step(1, 300);
        cfg_ratio = 1;
        step(1, 40); step(1, 60);
        step(0, 0);
        chk_out("ratio_chg", 50);
        step(0, 0);

        // Enable drop mid-window discards the partial window
        cfg_ratio = 2;
        step(1, 7); step(1, 7); step(1, 7);
        cfg_en = 1'b0;
        step(1, 7);
        cfg_en = 1'b1;
        step(1, 8); step(1, 8); step(1, 8); step(1, 8);
        step(0, 0);
        chk_out("en_drop", 8);
        step(0, 0);

        // Reset mid-window with a buffered result
        cfg_ready = 1'b0; cfg_ratio = 0;
        step(1, 77);
        cfg_ratio = 2;
        step(1, 1); step(1, 2);
        do_reset();
        cfg_en = 1'b1; cfg_ready = 1'b1; cfg_ratio = 2;
        repeat (3) step(0, 0);
        step(1, 20); step(1, 20); step(1, 20); step(1, 20);
        step(0, 0);
        chk_out("post_rst", 20);

        // Randomized traffic, including clamped ratios
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) cfg_ratio = int'($urandom_range(0, 7));
            cfg_en    = ($urandom_range(0, 99) != 0);
            cfg_ready = ($urandom_range(0, 9) < 7);
            cfg_clr   = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 9))
                0:       d = 32767;
                1:       d = -32768;
                default: d = int'($signed(16'($urandom())));
            endcase
            step(($urandom_range(0, 1) == 1), d);
        end

        // Drain
        cfg_ready = 1'b1; cfg_clr = 1'b0; cfg_en = 1'b0;
        repeat (4) step(0, 0);
        check("drain_empty", longint'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
